// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared types and constants for the I2C slave controller
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR1,
        ST_CHK1,
        ST_CHK2,
        ST_ACK_ADDR1,
        ST_ADDR2,
        ST_CHK3,
        ST_ACK_ADDR,
        ST_RX_BYTE,
        ST_ACK_DATA,
        ST_NACK_DATA,
        ST_TX_LOAD,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic [1:0] SDA_RELEASE = 2'b00;
    localparam logic [1:0] SDA_ACK     = 2'b01;
    localparam logic [1:0] SDA_TX      = 2'b10;

    localparam int         BITS_PER_BYTE = 8;
    localparam logic [3:0] LAST_BIT      = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] ACK_BIT       = 4'(BITS_PER_BYTE);

endpackage

// File: rtl/i2c_bit_counter.sv
// rtl/i2c_bit_counter.sv - SCL rising-edge counter spanning 8 data bits plus the ACK bit
module i2c_bit_counter
    import i2c_slave_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       count_en,
    output logic [3:0] bit_cnt
);

    // Wraps after the ACK bit so each byte frame restarts at zero on its own.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= 4'd0;
        end else if (clear) begin
            bit_cnt <= 4'd0;
        end else if (count_en) begin
            if (bit_cnt == ACK_BIT) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_controller.sv
// rtl/i2c_slave_controller.sv - slave-side I2C protocol FSM: address/data ACK and FIFO byte handoff
module i2c_slave_controller
    import i2c_slave_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] address_match,
    input  logic       rw_mode,
    input  logic       address_mode,
    input  logic       rising_edge,
    input  logic       falling_edge,
    input  logic       sda_sample,
    input  logic       rx_full,
    input  logic       tx_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       rw_store,
    output logic [1:0] sda_mode,
    output logic       rx_write,
    output logic       tx_read,
    output logic       ack_error,
    output logic       busy
);

    state_t     state;
    logic [3:0] bit_cnt;
    logic       addr10_ok;
    logic       cnt_clear;

    assign cnt_clear = start || stop || (state == ST_IDLE);

    i2c_bit_counter u_bit_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clear),
        .count_en (rising_edge),
        .bit_cnt  (bit_cnt)
    );

    // Shift-register strobes must coincide with the SCL edge strobe itself.
    assign rx_enable = rising_edge &&
                       ((state == ST_ADDR1) || (state == ST_ADDR2) || (state == ST_RX_BYTE));
    assign tx_enable = falling_edge && (state == ST_TX_BYTE) &&
                       (bit_cnt != 4'd0) && (bit_cnt <= LAST_BIT);
    assign busy      = (state != ST_IDLE) && (state != ST_WAIT_STOP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            sda_mode  <= SDA_RELEASE;
            addr10_ok <= 1'b0;
            rw_store  <= 1'b0;
            rx_write  <= 1'b0;
            load_data <= 1'b0;
            tx_read   <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            rw_store  <= 1'b0;
            rx_write  <= 1'b0;
            load_data <= 1'b0;
            tx_read   <= 1'b0;
            ack_error <= 1'b0;
            if (stop) begin
                state     <= ST_IDLE;
                sda_mode  <= SDA_RELEASE;
                addr10_ok <= 1'b0;
            end else if (start) begin
                state    <= ST_ADDR1;
                sda_mode <= SDA_RELEASE;
            end else begin
                case (state)
                    ST_ADDR1: begin
                        if (rising_edge && bit_cnt == LAST_BIT) begin
                            state    <= ST_CHK1;
                            rw_store <= 1'b1;
                        end
                    end
                    ST_CHK1: state <= ST_CHK2;
                    // A 10-bit read header is only honoured after a prior write header + low byte matched.
                    ST_CHK2: begin
                        if (!address_match[1]) begin
                            state <= ST_WAIT_STOP;
                        end else if (!address_mode) begin
                            state <= ST_ACK_ADDR;
                        end else if (!rw_mode) begin
                            state <= ST_ACK_ADDR1;
                        end else if (addr10_ok) begin
                            state <= ST_ACK_ADDR;
                        end else begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_ADDR2: begin
                        if (rising_edge && bit_cnt == LAST_BIT) begin
                            state <= ST_CHK3;
                        end
                    end
                    ST_CHK3: begin
                        if (address_match[0]) begin
                            addr10_ok <= 1'b1;
                            state     <= ST_ACK_ADDR;
                        end else begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_ACK_ADDR1, ST_ACK_ADDR, ST_ACK_DATA: begin
                        if (falling_edge && bit_cnt == ACK_BIT) begin
                            sda_mode <= SDA_ACK;
                        end else if (falling_edge && bit_cnt == 4'd0) begin
                            sda_mode <= SDA_RELEASE;
                            if (state == ST_ACK_ADDR1) begin
                                state <= ST_ADDR2;
                            end else if (state == ST_ACK_ADDR && rw_mode) begin
                                state     <= ST_TX_LOAD;
                                load_data <= 1'b1;
                                tx_read   <= !tx_empty;
                            end else begin
                                state <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (rising_edge && bit_cnt == LAST_BIT) begin
                            if (!rx_full) begin
                                rx_write <= 1'b1;
                                state    <= ST_ACK_DATA;
                            end else begin
                                state <= ST_NACK_DATA;
                            end
                        end
                    end
                    ST_NACK_DATA: begin
                        if (falling_edge && bit_cnt == 4'd0) begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_TX_LOAD: begin
                        state    <= ST_TX_BYTE;
                        sda_mode <= SDA_TX;
                    end
                    ST_TX_BYTE: begin
                        if (falling_edge && bit_cnt == ACK_BIT) begin
                            sda_mode <= SDA_RELEASE;
                            state    <= ST_TX_ACK;
                        end
                    end
                    ST_TX_ACK: begin
                        if (rising_edge && bit_cnt == ACK_BIT && sda_sample) begin
                            ack_error <= 1'b1;
                            state     <= ST_WAIT_STOP;
                        end else if (falling_edge && bit_cnt == 4'd0) begin
                            state     <= ST_TX_LOAD;
                            load_data <= 1'b1;
                            tx_read   <= !tx_empty;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
